// File: rtl/f1_pkg.sv
// ----------------------------------------------------------------------------
// f1_pkg
// Shared types and constants for the F1 start-light sequence blocks.
//   seq_state_t  : start-sequence controller states
//   LFSR_SEED    : non-zero reset value of the hold-delay LFSR
//   LFSR_TAPS    : tap mask for x^7 + x^3 + 1 (bits 6 and 2)
//   N_LIGHTS_DEF : default light FSM depth
// ----------------------------------------------------------------------------
package f1_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LIGHT,
      ST_HOLD,
      ST_GO,
      ST_DONE,
      ST_FAULT
   } seq_state_t;

   localparam logic [6:0] LFSR_SEED    = 7'h01;
   localparam logic [6:0] LFSR_TAPS    = 7'b100_0100;
   localparam int         N_LIGHTS_DEF = 8;

endpackage

// File: rtl/lfsr7.sv
// ----------------------------------------------------------------------------
// lfsr7
// Free-running Fibonacci LFSR (x^7 + x^3 + 1), advances every clock.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, loads LFSR_SEED
//   q     : current LFSR state (never zero)
// ----------------------------------------------------------------------------
module lfsr7
   import f1_pkg::*;
#(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;
   logic         w_fb;

   assign w_fb = ^(r_q & W'(LFSR_TAPS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= W'(LFSR_SEED);
      else        r_q <= {r_q[W-2:0], w_fb};
   end

   assign q = r_q;

endmodule

// File: rtl/f1_start_seq.sv
// ----------------------------------------------------------------------------
// f1_start_seq
// Start-sequence controller: steps the light FSM once per tick until all
// lights are lit, holds for a pseudo-random number of ticks, clears the
// lights and measures the driver's reaction time. Early react = jump start.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   tick       : one-cycle pacing pulse
//   trigger    : start request
//   react      : driver button
//   light_step : light FSM enable, one pulse per light (Mealy)
//   light_clr  : light FSM clear (all lights off)
//   done       : valid reaction result held
//   jump_start : react seen before lights out
//   react_time : reaction time in clk cycles (saturating)
// ----------------------------------------------------------------------------
module f1_start_seq
   import f1_pkg::*;
#(
   parameter int N_LIGHTS = N_LIGHTS_DEF,
   parameter int LFSR_W   = 7,
   parameter int TIME_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              trigger,
   input  logic              react,
   output logic              light_step,
   output logic              light_clr,
   output logic              done,
   output logic              jump_start,
   output logic [TIME_W-1:0] react_time
);

   localparam int                CNT_W = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_LIGHTS - 1);
   localparam logic [TIME_W-1:0] T_MAX = '1;

   seq_state_t        r_state;
   logic [CNT_W-1:0]  r_count;
   logic [LFSR_W-1:0] r_delay;
   logic [TIME_W-1:0] r_rtc;
   logic [TIME_W-1:0] r_react_time;
   logic [LFSR_W-1:0] w_lfsr;

   lfsr7 #(.W(LFSR_W)) u_lfsr (
      .clk   (clk),
      .rst_n (rst),
      .q     (w_lfsr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_delay      <= '0;
         r_rtc        <= '0;
         r_react_time <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (trigger) begin
                  r_state <= ST_LIGHT;
                  r_count <= '0;
               end
            end
            // react beats tick: a jump start suppresses the step pulse
            ST_LIGHT: begin
               if (react) begin
                  r_state <= ST_FAULT;
               end else if (tick) begin
                  r_count <= r_count + 1'b1;
                  if (r_count == LAST) begin
                     r_state <= ST_HOLD;
                     r_delay <= w_lfsr;
                  end
               end
            end
            ST_HOLD: begin
               if (react) begin
                  r_state <= ST_FAULT;
               end else if (tick) begin
                  if (r_delay == LFSR_W'(1)) begin
                     r_state <= ST_GO;
                     r_rtc   <= '0;
                  end else begin
                     r_delay <= r_delay - 1'b1;
                  end
               end
            end
            // rtc counts completed GO cycles, so react in the k-th cycle
            // sees rtc = k-1 and latches k
            ST_GO: begin
               if (react) begin
                  r_react_time <= (r_rtc == T_MAX) ? T_MAX : r_rtc + 1'b1;
                  r_state      <= ST_DONE;
               end else if (r_rtc != T_MAX) begin
                  r_rtc <= r_rtc + 1'b1;
               end
            end
            ST_DONE, ST_FAULT: begin
               if (trigger) begin
                  r_state      <= ST_LIGHT;
                  r_count      <= '0;
                  r_react_time <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign light_step = (r_state == ST_LIGHT) & tick & ~react;
   assign light_clr  = ~((r_state == ST_LIGHT) | (r_state == ST_HOLD));
   assign done       = (r_state == ST_DONE);
   assign jump_start = (r_state == ST_FAULT);
   assign react_time = r_react_time;

endmodule

// File: doc/f1_start_seq.md
# f1_start_seq

Start-sequence controller for the F1 lights display. It drives the downstream light FSM's clear and step inputs so that lights come on one per `tick`. After all lights are lit it holds them for a pseudo-random number of ticks, then extinguishes them and measures the driver's reaction time in clock cycles. It sits between the `clktick` pulse generator and the light FSM, and also flags jump starts.

## Interface
Parameters:
- `N_LIGHTS`, default 8: number of step pulses per sequence (light FSM depth).
- `LFSR_W`, default 7: hold-delay LFSR width.
- `TIME_W`, default 16: reaction-time counter width.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: one-cycle pacing pulse from `clktick`.
- `trigger`, input, 1: start request (level-sampled each cycle).
- `react`, input, 1: driver button (synchronised upstream).
- `light_step`, output, 1: drives light FSM `en`; one pulse per light.
- `light_clr`, output, 1: drives light FSM synchronous clear (all lights off).
- `done`, output, 1: valid reaction result held.
- `jump_start`, output, 1: react seen before lights out.
- `react_time`, output, `TIME_W`: reaction time in clk cycles.

## Operation
- States: IDLE, LIGHT, HOLD, GO, DONE, FAULT.
- IDLE: on `trigger`, go to LIGHT and set `count`=0. `react` is ignored.
- LIGHT: on `tick`, pulse `light_step` and increment `count`. When `tick` arrives with `count`=N_LIGHTS-1, go to HOLD and load `delay` from the LFSR.
- HOLD: on `tick`, decrement `delay`. When `tick` arrives with `delay`=1, go to GO.
- GO: `rtc` is 0 on entry and increments every cycle, saturating at all-ones. On `react`, latch `react_time`=min(`rtc`+1, max) and go to DONE.
- DONE / FAULT: hold results. On `trigger`, restart into LIGHT with `count`=0, `react_time` cleared to 0, and `done`/`jump_start` cleared.
- `react` in LIGHT or HOLD goes to FAULT (jump start). `react_time` is not updated.
- `trigger` is ignored in LIGHT, HOLD and GO.
- Output decode:
  - `light_step` = (state==LIGHT) & `tick` & ~`react`. This is Mealy and combinational.
  - `light_clr` = 1 in IDLE, GO, DONE and FAULT; 0 in LIGHT and HOLD.
  - `done` = (state==DONE).
  - `jump_start` = (state==FAULT).
- LFSR: `LFSR_W`-bit Fibonacci with polynomial x^7+x^3+1.
  - Seed is 7'h01. It advances every clk cycle in all states and is never zero.
  - Hold delay is therefore 1..127 ticks.
- Priorities:
  - `react` beats `tick` in LIGHT/HOLD: no step pulse, go to FAULT.
  - `trigger` beats everything in DONE/FAULT.
  - `tick` and `react` in the same GO cycle: `react` is counted normally.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state=IDLE, `count`=0, `delay`=0, `rtc`=0, LFSR=seed, `react_time`=0.
  - Outputs: `light_clr`=1, `light_step`=0, `done`=0, `jump_start`=0.
- Reset deassertion is synchronised by the environment; the first active edge follows it.
- Reset mid-sequence aborts immediately. Lights clear through `light_clr` combinationally on the reset assertion.
- Trigger-to-LIGHT latency is one edge. The first `light_step` requires a `tick` in LIGHT, so a `tick` in the same cycle as the accepted `trigger` is not used.
- Exactly N_LIGHTS `light_step` pulses occur per clean sequence. Any light FSM wrap is therefore never exercised.
- HOLD is entered on the edge of the Nth step `tick`. GO is entered on the edge of the `delay`-th subsequent `tick`.
- `light_clr` rises in the first GO cycle, so lights are off one cycle after the GO edge at the light FSM.
- `react` in the k-th GO cycle (first = 1) gives `react_time`=k. `done` is visible the following cycle.

## Structure
- Package `f1_pkg` holds:
  - the `seq_state_t` enum;
  - `LFSR_SEED` = 7'h01;
  - the LFSR tap mask;
  - the `N_LIGHTS` default.
- Sub-module `lfsr7`: free-running LFSR with async active-low reset to seed and a `q` output. It is reused by other lab blocks.
- Top level contains:
  - the state register;
  - next-state and Moore/Mealy output decode;
  - the `count`, `delay` and `rtc` counters;
  - the `react_time` latch.

## Test plan
- Reset mid-LIGHT after 3 steps → outputs return to reset values; `light_clr`=1, `done`=0, `react_time`=0.
- Clean run with `tick` every 4 cycles and LFSR state forced/predicted to 5 at HOLD entry:
  - 8 `light_step` pulses, then exactly 5 HOLD ticks, then GO;
  - `react` on the 20th GO cycle → `react_time`=20, `done`=1.
- `react` on the same cycle as the 4th LIGHT `tick` → no 4th step, FAULT, `jump_start`=1, `react_time`=0.
- `trigger` pulsed during LIGHT, HOLD and GO → ignored; step count stays 8 and the result is unchanged.
- DONE with `trigger` and `react` high together → restart into LIGHT, `done`=0, `react_time`=0.
- With `TIME_W`=4, `react` withheld for 20 GO cycles → `react_time`=15 (saturated).
